// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  localparam int WORD_BITS = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - fetch controller bus to memory and decode
interface instr_fetch_ctrl_if
  import mips_pkg::*;
#(
  parameter int W = WORD_BITS
);
  logic         run;
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_instr;
  logic [W-1:0] instr_out;
  logic [W-1:0] pc_out;
  logic [W-1:0] pc_plus4;
  logic         instr_valid;
  logic         halted;
  logic         fault;
  logic [W-1:0] fetch_count;

  modport master (
    output run, stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, instr_out, pc_out, pc_plus4, instr_valid, halted, fault, fetch_count
  );

  modport slave (
    input  run, stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, instr_out, pc_out, pc_plus4, instr_valid, halted, fault, fetch_count
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with load/hold/increment and range flags
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter int           W        = WORD_BITS,
  parameter int           DIR_MEM  = 1024,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load_reset,
  input  logic         i_load_target,
  input  logic         i_inc,
  input  logic [W-1:0] i_target,
  output logic [W-1:0] o_pc,
  output logic         o_target_misaligned,
  output logic         o_past_end
);
  // Highest byte address that still holds a full word.
  localparam logic [W-1:0] LAST_PC = W'(DIR_MEM - 4);

  logic [W-1:0] r_pc;

  // Restart beats redirect beats sequential increment; otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load_reset) begin
      r_pc <= RESET_PC;
    end else if (i_load_target) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + W'(PC_INC);
    end
  end

  assign o_pc                = r_pc;
  assign o_target_misaligned = |i_target[1:0];
  assign o_past_end          = (r_pc > LAST_PC);
endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer and fetch/decode register
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int              WORD     = WORD_BITS,
  parameter int              DIR_MEM  = 1024,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  instr_fetch_ctrl_if.slave   bus
);
  fetch_state_e    r_state, w_state_nxt;
  logic [WORD-1:0] r_instr, w_instr_nxt;
  logic [WORD-1:0] r_pc_out, w_pc_out_nxt;
  logic [WORD-1:0] r_count, w_count_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_halted, r_fault;

  logic [WORD-1:0] w_pc;
  logic            w_load_reset, w_load_target, w_inc;
  logic            w_misaligned, w_past_end;

  fetch_pc_reg #(
    .W        (WORD),
    .DIR_MEM  (DIR_MEM),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_load_reset        (w_load_reset),
    .i_load_target       (w_load_target),
    .i_inc               (w_inc),
    .i_target            (bus.redirect_pc),
    .o_pc                (w_pc),
    .o_target_misaligned (w_misaligned),
    .o_past_end          (w_past_end)
  );

  // Next-state and next-register logic; valid drops unless a word is delivered or held by stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_instr_nxt   = r_instr;
    w_pc_out_nxt  = r_pc_out;
    w_count_nxt   = r_count;
    w_valid_nxt   = 1'b0;
    w_load_reset  = 1'b0;
    w_load_target = 1'b0;
    w_inc         = 1'b0;
    case (r_state)
      IDLE, HALT, FAULT: begin
        if (bus.run) begin
          w_load_reset = 1'b1;
          w_count_nxt  = '0;
          w_state_nxt  = FETCH;
        end
      end
      FETCH: begin
        if (bus.redirect_valid && w_misaligned) begin
          w_state_nxt = FAULT;
        end else if (bus.redirect_valid) begin
          w_load_target = 1'b1;
        end else if (bus.stall) begin
          w_valid_nxt = r_valid;
        end else if (w_past_end) begin
          w_state_nxt = HALT;
        end else begin
          w_instr_nxt  = bus.imem_instr;
          w_pc_out_nxt = w_pc;
          w_valid_nxt  = 1'b1;
          w_inc        = 1'b1;
          w_count_nxt  = r_count + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and fetch/decode register update; halted/fault track the state entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_instr  <= NOP;
      r_pc_out <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= (w_state_nxt == HALT);
      r_fault  <= (w_state_nxt == FAULT);
    end
  end

  assign bus.imem_addr   = w_pc;
  assign bus.instr_out   = r_instr;
  assign bus.pc_out      = r_pc_out;
  assign bus.pc_plus4    = r_pc_out + WORD'(PC_INC);
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;
  assign bus.fetch_count = r_count;
endmodule
